// File: rtl/fp_pkg.sv
// Shared definitions for the FP coprocessor dispatch path (indecode/outdecode).
package fp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 3;

    localparam logic [TAG_W-1:0] OP_ADD  = 3'b000;
    localparam logic [TAG_W-1:0] OP_MUL  = 3'b001;
    localparam logic [TAG_W-1:0] OP_SINE = 3'b010;
    localparam logic [TAG_W-1:0] OP_NONE = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic op_legal(input logic [TAG_W-1:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SINE);
    endfunction

endpackage

// File: rtl/op_tag_fifo.sv
// In-order tag FIFO; head reads as all-ones when empty.
module op_tag_fifo #(
    parameter int unsigned W     = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '1 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/indecode.sv
// FP coprocessor input dispatcher: accepts one CPU request, issues it to the
// add/mul/sine unit with a one-cycle start pulse and records its tag in order.
module indecode
    import fp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cpu_push,
    input  logic [TAG_W-1:0]  cpu_opcode,
    input  logic [DATA_W-1:0] cpu_op_a,
    input  logic [DATA_W-1:0] cpu_op_b,
    output logic              cpu_hold,
    output logic              op_err,
    input  logic              add_busy,
    input  logic              mul_busy,
    input  logic              sine_busy,
    output logic              add_start,
    output logic              mul_start,
    output logic              sine_start,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    input  logic              op_fifo_pop,
    output logic [TAG_W-1:0]  fifo_out,
    output logic              op_fifo_empty
);
    state_t            state_q;
    logic [TAG_W-1:0]  opc_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              add_start_q, mul_start_q, sine_start_q, op_err_q;
    logic              fifo_full, unit_busy, issue_go;

    always_comb begin
        unit_busy = 1'b1;
        case (opc_q)
            OP_ADD:  unit_busy = add_busy;
            OP_MUL:  unit_busy = mul_busy;
            OP_SINE: unit_busy = sine_busy;
            default: unit_busy = 1'b1;
        endcase
    end

    assign cpu_hold = (state_q == ISSUE) | fifo_full;
    assign issue_go = (state_q == ISSUE) && !unit_busy && !fifo_full;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            opc_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            add_start_q  <= 1'b0;
            mul_start_q  <= 1'b0;
            sine_start_q <= 1'b0;
            op_err_q     <= 1'b0;
        end else begin
            add_start_q  <= 1'b0;
            mul_start_q  <= 1'b0;
            sine_start_q <= 1'b0;
            op_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_push && !cpu_hold) begin
                        opc_q <= cpu_opcode;
                        a_q   <= cpu_op_a;
                        b_q   <= cpu_op_b;
                        if (op_legal(cpu_opcode)) state_q  <= ISSUE;
                        else                      op_err_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_go) begin
                        add_start_q  <= (opc_q == OP_ADD);
                        mul_start_q  <= (opc_q == OP_MUL);
                        sine_start_q <= (opc_q == OP_SINE);
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag is pushed on the issue edge, so it is visible alongside the start pulse.
    op_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (issue_go),
        .pop   (op_fifo_pop),
        .din   (opc_q),
        .full  (fifo_full),
        .empty (op_fifo_empty),
        .head  (fifo_out)
    );

    assign add_start  = add_start_q;
    assign mul_start  = mul_start_q;
    assign sine_start = sine_start_q;
    assign op_err     = op_err_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;

endmodule

// File: tb/tb_indecode.sv
// Directed, table-driven bench for the indecode dispatcher.
module tb_indecode;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cpu_push;
    logic [2:0]  cpu_opcode;
    logic [31:0] cpu_op_a, cpu_op_b;
    logic        cpu_hold, op_err;
    logic        add_busy, mul_busy, sine_busy;
    logic        add_start, mul_start, sine_start;
    logic [31:0] unit_a, unit_b;
    logic        op_fifo_pop;
    logic [2:0]  fifo_out;
    logic        op_fifo_empty;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    indecode #(.DATA_W(32), .TAG_W(3), .DEPTH(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .cpu_push      (cpu_push),
        .cpu_opcode    (cpu_opcode),
        .cpu_op_a      (cpu_op_a),
        .cpu_op_b      (cpu_op_b),
        .cpu_hold      (cpu_hold),
        .op_err        (op_err),
        .add_busy      (add_busy),
        .mul_busy      (mul_busy),
        .sine_busy     (sine_busy),
        .add_start     (add_start),
        .mul_start     (mul_start),
        .sine_start    (sine_start),
        .unit_a        (unit_a),
        .unit_b        (unit_b),
        .op_fifo_pop   (op_fifo_pop),
        .fifo_out      (fifo_out),
        .op_fifo_empty (op_fifo_empty)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  exp_start;   // {sine, mul, add}
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cpu_push = 1'b1; cpu_opcode = op; cpu_op_a = a; cpu_op_b = b;
        step();
        cpu_push = 1'b0;
        step();
    endtask

    logic [2:0] tags [9];

    initial begin
        vecs[0] = '{3'b000, 32'h3F800000, 32'h40000000, 3'b001, 1'b0};
        vecs[1] = '{3'b001, 32'h40400000, 32'hC0800000, 3'b010, 1'b0};
        vecs[2] = '{3'b010, 32'h3FC90FDB, 32'hDEADBEEF, 3'b100, 1'b0};
        vecs[3] = '{3'b101, 32'h11111111, 32'h22222222, 3'b000, 1'b1};
        vecs[4] = '{3'b011, 32'h33333333, 32'h44444444, 3'b000, 1'b1};
        vecs[5] = '{3'b111, 32'h55555555, 32'h66666666, 3'b000, 1'b1};
        vecs[6] = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 3'b001, 1'b0};

        n_rst = 1'b0; cpu_push = 1'b0; cpu_opcode = '0; cpu_op_a = '0; cpu_op_b = '0;
        add_busy = 1'b0; mul_busy = 1'b0; sine_busy = 1'b0; op_fifo_pop = 1'b0;
        step(); step();
        check("rst_starts", {29'd0, sine_start, mul_start, add_start}, 32'd0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_err", op_err, 1'b0);
        check("rst_fifo_out", fifo_out, 3'b111);
        check("rst_empty", op_fifo_empty, 1'b1);
        check("rst_unit_a", unit_a, 32'd0);
        n_rst = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            cpu_push = 1'b1; cpu_opcode = vecs[i].op;
            cpu_op_a = vecs[i].a; cpu_op_b = vecs[i].b;
            step();
            cpu_push = 1'b0;
            check("vec_err_pulse", op_err, vecs[i].exp_err);
            check("vec_hold", cpu_hold, !vecs[i].exp_err);
            check("vec_no_early_start", {29'd0, sine_start, mul_start, add_start}, 32'd0);
            step();
            check("vec_start", {29'd0, sine_start, mul_start, add_start}, {29'd0, vecs[i].exp_start});
            check("vec_err_clear", op_err, 1'b0);
            check("vec_unit_a", unit_a, vecs[i].a);
            check("vec_unit_b", unit_b, vecs[i].b);
            check("vec_fifo_out", fifo_out, vecs[i].exp_err ? 3'b111 : vecs[i].op);
            check("vec_empty", op_fifo_empty, vecs[i].exp_err);
            step();
            check("vec_start_oneshot", {29'd0, sine_start, mul_start, add_start}, 32'd0);
            if (!vecs[i].exp_err) begin
                op_fifo_pop = 1'b1;
                step();
                op_fifo_pop = 1'b0;
                check("vec_pop_empty", op_fifo_empty, 1'b1);
            end
        end

        // Busy stall on the multiplier
        mul_busy = 1'b1;
        cpu_push = 1'b1; cpu_opcode = 3'b001; cpu_op_a = 32'h12345678; cpu_op_b = 32'h9ABCDEF0;
        step();
        cpu_push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_hold", cpu_hold, 1'b1);
            check("stall_no_start", mul_start, 1'b0);
            check("stall_unit_a", unit_a, 32'h12345678);
        end
        mul_busy = 1'b0;
        step();
        check("stall_release_start", mul_start, 1'b1);
        check("stall_fifo_out", fifo_out, 3'b001);
        step();
        check("stall_start_oneshot", mul_start, 1'b0);
        op_fifo_pop = 1'b1;
        step();
        op_fifo_pop = 1'b0;
        check("stall_pop_empty", op_fifo_empty, 1'b1);

        // Fill the FIFO, then pop once to let a ninth op in
        for (int i = 0; i < 9; i++) tags[i] = 3'(i % 3);
        for (int i = 0; i < 8; i++) issue(tags[i], 32'(i), 32'(i + 100));
        check("full_hold", cpu_hold, 1'b1);
        check("full_not_empty", op_fifo_empty, 1'b0);
        cpu_push = 1'b1; cpu_opcode = tags[8]; cpu_op_a = 32'hAAAA0008; cpu_op_b = 32'hBBBB0008;
        step(); step();
        check("full_blocked_start", {29'd0, sine_start, mul_start, add_start}, 32'd0);
        check("full_blocked_unit_a", unit_a, 32'd7);
        check("full_head", fifo_out, tags[0]);
        op_fifo_pop = 1'b1;
        step();
        op_fifo_pop = 1'b0;
        check("full_pop_hold_drops", cpu_hold, 1'b0);
        step();
        cpu_push = 1'b0;
        check("ninth_accept_hold", cpu_hold, 1'b1);
        check("ninth_unit_a", unit_a, 32'hAAAA0008);
        step();
        check("ninth_start", {29'd0, sine_start, mul_start, add_start}, 32'd1 << tags[8]);
        for (int i = 1; i < 9; i++) begin
            check("drain_order", fifo_out, tags[i]);
            op_fifo_pop = 1'b1;
            step();
            op_fifo_pop = 1'b0;
        end
        check("drain_fifo_out", fifo_out, 3'b111);
        check("drain_empty", op_fifo_empty, 1'b1);
        op_fifo_pop = 1'b1;
        step();
        op_fifo_pop = 1'b0;
        check("pop_when_empty", op_fifo_empty, 1'b1);

        // Reset while a sine issue is stalled
        sine_busy = 1'b1;
        issue(3'b010, 32'h3F000000, 32'h0);
        check("mid_pending_hold", cpu_hold, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_hold", cpu_hold, 1'b0);
        check("mid_rst_empty", op_fifo_empty, 1'b1);
        step();
        sine_busy = 1'b0;
        n_rst = 1'b1;
        step();
        check("mid_no_start", sine_start, 1'b0);
        step();
        check("mid_no_start_late", sine_start, 1'b0);
        check("mid_idle", cpu_hold, 1'b0);
        check("mid_fifo_out", fifo_out, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
